// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_sub
//  Description : Digit-serial adder/subtractor, LSB digit first, with signed
//                and unsigned result formats and valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sub #(
  parameter int DATA_WD  = 16,
  parameter int DIGIT_WD = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_WD-1:0] i_a,
  input  logic [DATA_WD-1:0] i_b,
  input  logic [1:0]         i_mode,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_WD:0]   o_arith_out,
  output logic               o_ovr
);

  localparam int N      = DATA_WD / DIGIT_WD;
  localparam int MSB    = DATA_WD - 1;
  localparam int CNT_WD = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_WD-1:0] LAST_DIGIT = CNT_WD'(N - 1);

  generate
    if (DATA_WD % DIGIT_WD != 0) begin : g_bad_cfg
      $error("serial_add_sub: DIGIT_WD (%0d) must divide DATA_WD (%0d)", DIGIT_WD, DATA_WD);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_WD-1:0]  r_a;
  logic [DATA_WD-1:0]  r_b;
  logic [DATA_WD-1:0]  r_sum;
  logic                r_a_msb;
  logic                r_b_msb;
  logic                r_sub;
  logic                r_signed;
  logic                r_carry;
  logic [CNT_WD-1:0]   r_cnt;
  logic [DATA_WD:0]    r_arith_out;
  logic                r_ovr;

  logic [DIGIT_WD-1:0]         w_dig_a;
  logic [DIGIT_WD-1:0]         w_dig_b;
  logic [DIGIT_WD-1:0]         w_dig_sum;
  logic [DIGIT_WD:0]           w_chain;
  logic                        w_carry_out;
  logic [DATA_WD+DIGIT_WD-1:0] w_sum_wide;
  logic [DATA_WD+DIGIT_WD-1:0] w_a_wide;
  logic [DATA_WD+DIGIT_WD-1:0] w_b_wide;
  logic [DATA_WD-1:0]          w_sum_next;
  logic [DATA_WD-1:0]          w_a_next;
  logic [DATA_WD-1:0]          w_b_next;
  logic                        w_sign_ext;
  logic                        w_s_msb;
  logic [DATA_WD:0]            w_res;
  logic                        w_ovr;

  assign w_dig_a = r_a[DIGIT_WD-1:0];
  assign w_dig_b = r_b[DIGIT_WD-1:0];

  // One digit of ripple-carry addition, seeded by the inter-digit carry register.
  always_comb begin
    w_chain    = '0;
    w_dig_sum  = '0;
    w_chain[0] = r_carry;
    for (int i = 0; i < DIGIT_WD; i++) begin
      w_dig_sum[i]   = w_dig_a[i] ^ w_dig_b[i] ^ w_chain[i];
      w_chain[i+1]   = (w_dig_a[i] & w_dig_b[i]) | (w_chain[i] & (w_dig_a[i] ^ w_dig_b[i]));
    end
  end

  assign w_carry_out = w_chain[DIGIT_WD];

  // Widened shifts stay legal when a single digit spans the whole operand.
  assign w_sum_wide = {w_dig_sum, r_sum} >> DIGIT_WD;
  assign w_a_wide   = {{DIGIT_WD{1'b0}}, r_a} >> DIGIT_WD;
  assign w_b_wide   = {{DIGIT_WD{1'b0}}, r_b} >> DIGIT_WD;
  assign w_sum_next = w_sum_wide[DATA_WD-1:0];
  assign w_a_next   = w_a_wide[DATA_WD-1:0];
  assign w_b_next   = w_b_wide[DATA_WD-1:0];

  // r_b_msb already holds the inverted MSB for subtraction, so one formula covers both.
  assign w_s_msb    = w_sum_next[MSB];
  assign w_sign_ext = r_a_msb ^ r_b_msb ^ w_carry_out;

  always_comb begin
    w_res = {1'b0, w_sum_next};
    w_ovr = 1'b0;
    case ({r_signed, r_sub})
      2'b00: begin
        w_res = {w_carry_out, w_sum_next};
        w_ovr = 1'b0;
      end
      2'b01: begin
        w_res = {1'b0, w_sum_next};
        w_ovr = ~w_carry_out;
      end
      default: begin
        w_res = {w_sign_ext, w_sum_next};
        w_ovr = (r_a_msb == r_b_msb) && (w_s_msb != r_a_msb);
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_arith_out <= '0;
      r_ovr       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_sub       <= 1'b0;
      r_signed    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_a      <= i_a;
            r_b      <= i_mode[0] ? ~i_b : i_b;
            r_a_msb  <= i_a[MSB];
            r_b_msb  <= i_mode[0] ? ~i_b[MSB] : i_b[MSB];
            r_sub    <= i_mode[0];
            r_signed <= i_mode[1];
            r_carry  <= i_mode[0];
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a     <= w_a_next;
          r_b     <= w_b_next;
          r_sum   <= w_sum_next;
          r_carry <= w_carry_out;
          r_cnt   <= r_cnt + CNT_WD'(1);
          if (r_cnt == LAST_DIGIT) begin
            r_arith_out <= w_res;
            r_ovr       <= w_ovr;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready     = (r_state == IDLE);
  assign o_valid     = (r_state == DONE);
  assign o_arith_out = r_arith_out;
  assign o_ovr       = r_ovr;

endmodule
`default_nettype wire
